// File: rtl/channel_fir.sv
`default_nettype none
// ============================================================================
// Module   : channel_fir
// Purpose  : decimating real-coefficient I/Q FIR, one shared MAC pass per output
// Revision : 1.0
// ============================================================================
module channel_fir #(
   parameter int DATA_WIDTH = 32,
   parameter int QUANT_BITS = 10,
   parameter int TAPS       = 20,
   parameter int DECIM      = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_avail,
   input  logic signed [DATA_WIDTH-1:0] i_in,
   input  logic signed [DATA_WIDTH-1:0] q_in,
   output logic                         in_rd_en,
   input  logic                         coef_we,
   input  logic [$clog2(TAPS)-1:0]      coef_addr,
   input  logic signed [DATA_WIDTH-1:0] coef_data,
   output logic signed [DATA_WIDTH-1:0] i_out,
   output logic signed [DATA_WIDTH-1:0] q_out,
   output logic                         out_avail,
   input  logic                         out_rd_en
);

   localparam int TAP_W  = $clog2(TAPS);
   localparam int CNT_W  = $clog2(DECIM + 1);
   localparam int PROD_W = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {
      S_FILL    = 2'd0,
      S_COMPUTE = 2'd1,
      S_OUTPUT  = 2'd2
   } state_t;

   state_t                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [TAP_W-1:0]             tap_q, tap_d;
   logic signed [DATA_WIDTH-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic signed [DATA_WIDTH-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
   logic signed [DATA_WIDTH-1:0] x_i_q [TAPS];
   logic signed [DATA_WIDTH-1:0] x_i_d [TAPS];
   logic signed [DATA_WIDTH-1:0] x_q_q [TAPS];
   logic signed [DATA_WIDTH-1:0] x_q_d [TAPS];
   logic signed [DATA_WIDTH-1:0] coef_q [TAPS];
   logic signed [DATA_WIDTH-1:0] coef_d [TAPS];

   logic signed [PROD_W-1:0]     prod_i, prod_q;
   logic signed [DATA_WIDTH-1:0] term_i, term_q, sum_i, sum_q;
   logic                         coef_ok;

   // Full-width signed products, floored by the arithmetic shift, then wrapped.
   assign prod_i = PROD_W'(x_i_q[tap_q]) * PROD_W'(coef_q[tap_q]);
   assign prod_q = PROD_W'(x_q_q[tap_q]) * PROD_W'(coef_q[tap_q]);
   assign term_i = DATA_WIDTH'(prod_i >>> QUANT_BITS);
   assign term_q = DATA_WIDTH'(prod_q >>> QUANT_BITS);
   assign sum_i  = acc_i_q + term_i;
   assign sum_q  = acc_q_q + term_q;

   assign coef_ok = coef_we && (state_q != S_COMPUTE) &&
                    ({1'b0, coef_addr} < (TAP_W + 1)'(TAPS));

   assign i_out     = i_out_q;
   assign q_out     = q_out_q;
   assign out_avail = (state_q == S_OUTPUT);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tap_d    = tap_q;
      acc_i_d  = acc_i_q;
      acc_q_d  = acc_q_q;
      i_out_d  = i_out_q;
      q_out_d  = q_out_q;
      x_i_d    = x_i_q;
      x_q_d    = x_q_q;
      coef_d   = coef_q;
      in_rd_en = 1'b0;

      case (state_q)
         S_FILL: begin
            in_rd_en = in_avail;
            if (in_avail) begin
               x_i_d[0] = i_in;
               x_q_d[0] = q_in;
               for (int k = 1; k < TAPS; k++) begin
                  x_i_d[k] = x_i_q[k-1];
                  x_q_d[k] = x_q_q[k-1];
               end
               if (cnt_q == CNT_W'(DECIM - 1)) begin
                  cnt_d   = '0;
                  tap_d   = '0;
                  acc_i_d = '0;
                  acc_q_d = '0;
                  state_d = S_COMPUTE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_COMPUTE: begin
            acc_i_d = sum_i;
            acc_q_d = sum_q;
            tap_d   = tap_q + TAP_W'(1);
            // Last tap goes straight into the output registers.
            if (tap_q == TAP_W'(TAPS - 1)) begin
               tap_d   = '0;
               i_out_d = sum_i;
               q_out_d = sum_q;
               state_d = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (out_rd_en) begin
               state_d = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase

      if (coef_ok) begin
         coef_d[coef_addr] = coef_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_FILL;
         cnt_q   <= '0;
         tap_q   <= '0;
         acc_i_q <= '0;
         acc_q_q <= '0;
         i_out_q <= '0;
         q_out_q <= '0;
         x_i_q   <= '{default: '0};
         x_q_q   <= '{default: '0};
         coef_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tap_q   <= tap_d;
         acc_i_q <= acc_i_d;
         acc_q_q <= acc_q_d;
         i_out_q <= i_out_d;
         q_out_q <= q_out_d;
         x_i_q   <= x_i_d;
         x_q_q   <= x_q_d;
         coef_q  <= coef_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_channel_fir.sv
`default_nettype none
// ============================================================================
// Module   : tb_channel_fir
// Purpose  : scoreboard bench for channel_fir against a queue-based FIR model
// Revision : 1.0
// ============================================================================
module tb_channel_fir;

   localparam int DW    = 32;
   localparam int QB    = 10;
   localparam int TAPS  = 20;
   localparam int DECIM = 8;
   localparam int AW    = $clog2(TAPS);

   logic                 clock     = 1'b0;
   logic                 reset     = 1'b0;
   logic                 in_avail  = 1'b0;
   logic                 coef_we   = 1'b0;
   logic                 out_rd_en = 1'b0;
   logic signed [DW-1:0] i_in      = '0;
   logic signed [DW-1:0] q_in      = '0;
   logic signed [DW-1:0] coef_data = '0;
   logic [AW-1:0]        coef_addr = '0;
   logic                 in_rd_en;
   logic                 out_avail;
   logic signed [DW-1:0] i_out;
   logic signed [DW-1:0] q_out;

   channel_fir #(
      .DATA_WIDTH(DW),
      .QUANT_BITS(QB),
      .TAPS      (TAPS),
      .DECIM     (DECIM)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .in_avail (in_avail),
      .i_in     (i_in),
      .q_in     (q_in),
      .in_rd_en (in_rd_en),
      .coef_we  (coef_we),
      .coef_addr(coef_addr),
      .coef_data(coef_data),
      .i_out    (i_out),
      .q_out    (q_out),
      .out_avail(out_avail),
      .out_rd_en(out_rd_en)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: coefficient image, sample history (newest first),
   // expected-output queues and the decimation phase.
   int  mc [TAPS];
   int  hist_i [$];
   int  hist_q [$];
   int  exp_i  [$];
   int  exp_q  [$];
   int  cnt     = 0;
   bit  pending = 1'b0;
   bit  accepted;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(req));
      end
   endtask

   function automatic int fir(input bit use_q);
      int     acc;
      longint x;
      longint p;
      acc = 0;
      for (int k = 0; k < TAPS; k++) begin
         if (use_q) x = (k < hist_q.size()) ? longint'(hist_q[k]) : 64'sd0;
         else       x = (k < hist_i.size()) ? longint'(hist_i[k]) : 64'sd0;
         p   = x * longint'(mc[k]);
         acc = acc + int'(p >>> QB);
      end
      return acc;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < TAPS; k++) mc[k] = 0;
      hist_i.delete();
      hist_q.delete();
      exp_i.delete();
      exp_q.delete();
      cnt     = 0;
      pending = 1'b0;
   endtask

   // Called at the falling edge: records what the next rising edge commits.
   task automatic observe();
      accepted = 1'b0;
      if (reset) return;
      if (coef_we && (int'(coef_addr) < TAPS) && (!pending || out_avail))
         mc[coef_addr] = coef_data;
      if (in_avail && in_rd_en) begin
         accepted = 1'b1;
         hist_i.push_front(i_in);
         hist_q.push_front(q_in);
         if (hist_i.size() > TAPS) begin
            void'(hist_i.pop_back());
            void'(hist_q.pop_back());
         end
         cnt++;
         if (cnt == DECIM) begin
            cnt = 0;
            exp_i.push_back(fir(1'b0));
            exp_q.push_back(fir(1'b1));
            pending = 1'b1;
         end
      end
      if (out_avail && out_rd_en) pending = 1'b0;
   endtask

   task automatic step();
      @(negedge clock);
      observe();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (!reset && out_avail && out_rd_en) begin
         if (exp_i.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got (%0d,%0d), expected no output", i_out, q_out);
         end else begin
            chk("out_i", i_out, exp_i.pop_front());
            chk("out_q", q_out, exp_q.pop_front());
         end
      end
   end

   function automatic int rnd_sample();
      if ($urandom_range(0, 3) == 0) return int'($urandom);
      return int'($urandom_range(0, 8191)) - 4096;
   endfunction

   task automatic load(input int addr, input int data);
      coef_we   = 1'b1;
      coef_addr = AW'(addr);
      coef_data = data;
      step();
      coef_we   = 1'b0;
   endtask

   task automatic send(input int si, input int sq);
      in_avail = 1'b1;
      i_in     = si;
      q_in     = sq;
      for (int t = 0; t < 200; t++) begin
         step();
         if (accepted) break;
      end
      chk("send_timeout", 32'(accepted), 32'd1);
      in_avail = 1'b0;
   endtask

   task automatic drain();
      in_avail  = 1'b0;
      out_rd_en = 1'b1;
      for (int t = 0; t < 400; t++) begin
         if (exp_i.size() == 0) break;
         step();
      end
      chk("drain_timeout", exp_i.size(), 0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_avail = 1'b0;
      coef_we  = 1'b0;
      model_clear();
      #2;
      chk("rst_i_out", i_out, 0);
      chk("rst_q_out", q_out, 0);
      chk("rst_out_avail", 32'(out_avail), 32'd0);
      step();
      reset    = 1'b0;
      in_avail = 1'b1;
      #1;
      chk("rst_in_rd_en_follows", 32'(in_rd_en), 32'd1);
      in_avail = 1'b0;
      #1;
      chk("rst_in_rd_en_idle", 32'(in_rd_en), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      #1;
      do_reset();

      // Impulse response with ramp coefficients.
      for (int k = 0; k < TAPS; k++) load(k, (k + 1) * 1024);
      out_rd_en = 1'b1;
      send(1024, -1024);
      repeat (31) send(0, 0);
      drain();

      // DC gain from a fresh state.
      do_reset();
      for (int k = 0; k < TAPS; k++) load(k, 1024);
      repeat (40) send(512, -3);
      drain();

      // Floor rounding through a single-tap filter.
      for (int k = 0; k < TAPS; k++) load(k, (k == 0) ? 1 : 0);
      repeat (2) begin
         repeat (DECIM - 1) send(0, 0);
         send(-1, 1023);
      end
      drain();

      // Backpressure: output held while input stays offered.
      for (int k = 0; k < TAPS; k++) load(k, int'($urandom_range(0, 4095)) - 2048);
      out_rd_en = 1'b0;
      repeat (DECIM) send(rnd_sample(), rnd_sample());
      in_avail = 1'b1;
      i_in     = 77;
      q_in     = -77;
      for (int t = 0; t < 100; t++) begin
         if (out_avail) break;
         step();
      end
      chk("bp_out_avail_rise", 32'(out_avail), 32'd1);
      repeat (50) begin
         #3;
         chk("bp_out_avail", 32'(out_avail), 32'd1);
         chk("bp_in_rd_en", 32'(in_rd_en), 32'd0);
         if (exp_i.size() > 0) begin
            chk("bp_i_stable", i_out, exp_i[0]);
            chk("bp_q_stable", q_out, exp_q[0]);
         end
         step();
         chk("bp_no_consume", 32'(accepted), 32'd0);
      end
      out_rd_en = 1'b1;
      repeat (DECIM) send(rnd_sample(), rnd_sample());
      drain();

      // Coefficient write mid-COMPUTE is dropped; the same write in FILL lands.
      for (int k = 0; k < TAPS; k++) load(k, int'($urandom_range(0, 4095)) - 2048);
      repeat (DECIM) send(rnd_sample(), rnd_sample());
      repeat (3) step();
      chk("mid_compute_idle", 32'(out_avail), 32'd0);
      load(0, 12345);
      drain();
      repeat (DECIM) send(rnd_sample(), rnd_sample());
      drain();
      load(0, 12345);
      repeat (DECIM) send(rnd_sample(), rnd_sample());
      drain();

      // Reset in the middle of COMPUTE, then a clean output afterwards.
      repeat (DECIM) send(rnd_sample(), rnd_sample());
      repeat (4) step();
      do_reset();
      for (int k = 0; k < TAPS; k++) load(k, int'($urandom_range(0, 4095)) - 2048);
      out_rd_en = 1'b1;
      repeat (2 * DECIM) send(rnd_sample(), rnd_sample());
      drain();

      // Randomized traffic with interleaved coefficient writes.
      repeat (800) begin
         in_avail  = ($urandom_range(0, 3) != 0);
         i_in      = rnd_sample();
         q_in      = rnd_sample();
         coef_we   = ($urandom_range(0, 9) == 0);
         coef_addr = AW'($urandom_range(0, (1 << AW) - 1));
         coef_data = rnd_sample();
         out_rd_en = ($urandom_range(0, 2) != 0);
         step();
      end
      coef_we = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
